// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor
// Bridges the L2 controller's full-line pmem handshake onto a beat-oriented
// burst memory bus. A line is split into BEATS little-endian beats on writes
// and reassembled from beats on reads; pmem_resp pulses once per transfer.
module l2_cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [ADDR_W-1:0]  pmem_address,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic               bmem_read,
  output logic               bmem_write,
  output logic [ADDR_W-1:0]  bmem_address,
  output logic [BURST_W-1:0] bmem_wdata,
  input  logic [BURST_W-1:0] bmem_rdata,
  input  logic               bmem_resp
);

  localparam int BEATS  = LINE_W / BURST_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  // Byte-offset bits inside one line are cleared so the burst is line aligned.
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [BEATS-1:0][BURST_W-1:0] lineBuf_q, lineBuf_d;
  logic [LINE_W-1:0]             rdataLine_q, rdataLine_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;

  // State, beat counter and data buffers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      lineBuf_q   <= '0;
      rdataLine_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      lineBuf_q   <= lineBuf_d;
      rdataLine_q <= rdataLine_d;
      addr_q      <= addr_d;
    end
  end

  // Next-state logic: accept one request in IDLE, then count beats on bmem_resp.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lineBuf_d   = lineBuf_q;
    rdataLine_d = rdataLine_q;
    addr_d      = addr_q;

    case (state_q)
      IDLE: begin
        // Exactly one of read/write must be asserted; both or neither is ignored.
        if (pmem_read ^ pmem_write) begin
          addr_d = pmem_address & ~OFFSET_MASK;
          if (pmem_read) begin
            state_d = RD_BURST;
          end else begin
            lineBuf_d = pmem_wdata;
            state_d   = WR_BURST;
          end
        end
      end

      RD_BURST: begin
        if (bmem_resp) begin
          lineBuf_d[beat_q] = bmem_rdata;
          if (beat_q == LAST_BEAT) begin
            // The visible read line only changes when a read completes.
            beat_d      = '0;
            rdataLine_d = lineBuf_d;
            state_d     = DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      WR_BURST: begin
        if (bmem_resp) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bmem_read    = (state_q == RD_BURST);
  assign bmem_write   = (state_q == WR_BURST);
  assign pmem_resp    = (state_q == DONE);
  assign bmem_address = addr_q;
  assign pmem_rdata   = rdataLine_q;
  assign bmem_wdata   = (state_q == WR_BURST) ? lineBuf_q[beat_q] : '0;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb_l2_cacheline_adaptor
// Self-checking bench: the bench plays both the L2 controller and a burst
// memory with random stalls, and checks every cycle against a line-level
// model of what the adaptor must show on its ports.
module tb_l2_cacheline_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;

  logic               clk;
  logic               rst;
  logic               pmem_read;
  logic               pmem_write;
  logic [ADDR_W-1:0]  pmem_address;
  logic [LINE_W-1:0]  pmem_wdata;
  logic [LINE_W-1:0]  pmem_rdata;
  logic               pmem_resp;
  logic               bmem_read;
  logic               bmem_write;
  logic [ADDR_W-1:0]  bmem_address;
  logic [BURST_W-1:0] bmem_wdata;
  logic [BURST_W-1:0] bmem_rdata;
  logic               bmem_resp;

  int numCompared   = 0;
  int numMismatched = 0;

  // Line-level model: last line returned to the controller and last burst address.
  logic [LINE_W-1:0] rdataModel;
  logic [ADDR_W-1:0] addrModel;

  l2_cacheline_adaptor #(
    .LINE_W (LINE_W),
    .BURST_W(BURST_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_address(bmem_address),
    .bmem_wdata  (bmem_wdata),
    .bmem_rdata  (bmem_rdata),
    .bmem_resp   (bmem_resp)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if a task misbehaves.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                             input logic [LINE_W-1:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Random full-width line built from 32-bit chunks.
  function automatic logic [LINE_W-1:0] randLine();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Stall count before a beat: negative mode means random 0..3 cycles.
  function automatic int pickStall(input int stallMode);
    if (stallMode < 0) return $urandom_range(0, 3);
    return stallMode;
  endfunction

  // Every output must read zero, as right after reset.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bmem_read"},    bmem_read,    '0);
    checkOutput({tag, "_bmem_write"},   bmem_write,   '0);
    checkOutput({tag, "_pmem_resp"},    pmem_resp,    '0);
    checkOutput({tag, "_pmem_rdata"},   pmem_rdata,   '0);
    checkOutput({tag, "_bmem_address"}, bmem_address, '0);
    checkOutput({tag, "_bmem_wdata"},   bmem_wdata,   '0);
  endtask

  // One full line transfer. Called just after a rising edge with the adaptor
  // idle; returns just after the edge into the first idle cycle afterwards,
  // with the request dropped. The memory side returns line beat k as the k-th
  // beat (little-endian) after a chosen number of stall cycles per beat.
  task automatic applyStimulus(input bit isWrite, input logic [ADDR_W-1:0] addr,
                               input logic [LINE_W-1:0] line, input int stallMode);
    logic [ADDR_W-1:0] expAddr;
    int beatsDone;
    int stallLeft;
    int totalStall;
    int cycles;
    bit done;

    expAddr    = addr & ~ADDR_W'(LINE_W / 8 - 1);
    pmem_read  = !isWrite;
    pmem_write = isWrite;
    pmem_address = addr;
    pmem_wdata = isWrite ? line : randLine();
    bmem_resp  = 1'b0;

    beatsDone  = 0;
    stallLeft  = pickStall(stallMode);
    totalStall = stallLeft;
    cycles     = 0;
    done       = 1'b0;

    while (!done && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      // Latched copies must be used: scramble the controller side mid-burst.
      pmem_address = $urandom;
      pmem_wdata   = randLine();
      bmem_resp    = 1'b0;
      bmem_rdata   = {$urandom, $urandom};

      if (beatsDone < BEATS) begin
        checkOutput("bmem_read",       bmem_read,    !isWrite);
        checkOutput("bmem_write",      bmem_write,   isWrite);
        checkOutput("pmem_resp_early", pmem_resp,    '0);
        checkOutput("bmem_address",    bmem_address, expAddr);
        checkOutput("pmem_rdata_hold", pmem_rdata,   rdataModel);
        if (isWrite) checkOutput("bmem_wdata", bmem_wdata, line[beatsDone*BURST_W +: BURST_W]);

        if (stallLeft > 0) begin
          stallLeft--;
        end else begin
          bmem_resp  = 1'b1;
          bmem_rdata = line[beatsDone*BURST_W +: BURST_W];
          beatsDone++;
          if (beatsDone < BEATS) begin
            stallLeft  = pickStall(stallMode);
            totalStall += stallLeft;
          end
        end
      end else begin
        // All beats handed over: this is the completion cycle.
        if (!isWrite) rdataModel = line;
        checkOutput("pmem_resp",        pmem_resp,  1'b1);
        checkOutput("done_bmem_read",   bmem_read,  '0);
        checkOutput("done_bmem_write",  bmem_write, '0);
        checkOutput("done_pmem_rdata",  pmem_rdata, rdataModel);
        // Cycle number of pmem_resp, counting the request cycle as cycle 1.
        checkOutput("latency", cycles + 1, 2 + BEATS + totalStall);
        done = 1'b1;
      end
    end
    if (!done) checkOutput("txn_timeout", '0, 1'b1);

    // Request stays high through the response cycle; it must not restart.
    @(posedge clk);
    #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    bmem_resp  = 1'b0;
    addrModel  = expAddr;
    checkOutput("resp_single_pulse", pmem_resp,    '0);
    checkOutput("idle_bmem_read",    bmem_read,    '0);
    checkOutput("idle_bmem_write",   bmem_write,   '0);
    checkOutput("idle_bmem_address", bmem_address, addrModel);
    checkOutput("idle_pmem_rdata",   pmem_rdata,   rdataModel);
  endtask

  // Idle or illegal cycles: with bothHigh set, read and write are raised
  // together; spurious bmem_resp pulses are thrown in. Nothing may start.
  task automatic idleCycles(input int n, input bit bothHigh);
    for (int i = 0; i < n; i++) begin
      pmem_read    = bothHigh;
      pmem_write   = bothHigh;
      pmem_address = $urandom;
      bmem_resp    = 1'($urandom_range(0, 1));
      bmem_rdata   = {$urandom, $urandom};
      @(posedge clk);
      #1;
      checkOutput("quiet_bmem_read",    bmem_read,    '0);
      checkOutput("quiet_bmem_write",   bmem_write,   '0);
      checkOutput("quiet_pmem_resp",    pmem_resp,    '0);
      checkOutput("quiet_bmem_address", bmem_address, addrModel);
      checkOutput("quiet_pmem_rdata",   pmem_rdata,   rdataModel);
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    bmem_resp  = 1'b0;
  endtask

  // Start a read, hand over two beats, then reset between clock edges.
  task automatic resetMidBurst();
    pmem_read    = 1'b1;
    pmem_address = $urandom;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_bmem_read", bmem_read, 1'b1);
    bmem_resp  = 1'b1;
    bmem_rdata = {$urandom, $urandom};
    @(posedge clk);
    #1;
    bmem_rdata = {$urandom, $urandom};
    @(posedge clk);
    #1;
    bmem_resp = 1'b0;
    #2 rst = 1'b1;
    #1;
    rdataModel = '0;
    addrModel  = '0;
    checkAllZero("midburst_reset");
    #2 rst = 1'b0;
    pmem_read = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("after_reset");
  endtask

  // Directed scenarios first, then a randomized mix of transfers and noise.
  initial begin
    rst          = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    bmem_rdata   = '0;
    bmem_resp    = 1'b0;
    rdataModel   = '0;
    addrModel    = '0;

    #1 rst = 1'b1;
    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] read without stalls");
    applyStimulus(1'b0, 32'h0000_1234,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0);
    checkOutput("read_bmem_address", bmem_address, 32'h0000_1220);

    $display("[TB] write with 3-cycle stalls");
    applyStimulus(1'b1, 32'h0000_2008,
                  {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 3);

    $display("[TB] write-back then allocate");
    applyStimulus(1'b1, 32'h0000_0040, randLine(), -1);
    applyStimulus(1'b0, 32'h0000_0080, randLine(), -1);
    checkOutput("alloc_bmem_address", bmem_address, 32'h0000_0080);

    $display("[TB] illegal and spurious inputs");
    idleCycles(5, 1'b1);

    $display("[TB] reset mid-burst");
    resetMidBurst();
    applyStimulus(1'b0, $urandom, randLine(), 0);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: idleCycles($urandom_range(1, 3), 1'b0);
        1: idleCycles($urandom_range(1, 2), 1'b1);
        default: ;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), $urandom, randLine(), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
